// File: rtl/tinyqv_instr_fetch_qspi.sv
// Instruction-fetch front end for tinyqv_cpu: converts fetch requests into
// quad-SPI continuous-read (0xEB mode, no command byte) transactions and returns
// 16-bit halfwords.
//
// Ports:
//   clk, rst              system clock, async active-high reset
//   instr_addr            halfword address [23:1], sampled on restart
//   instr_fetch_restart   pulse: abandon current stream, fetch from instr_addr
//   instr_fetch_stall     level: pause the stream at the next halfword boundary
//   instr_fetch_started   pulse in the first address-phase cycle
//   instr_fetch_stopped   pulse in the first cycle spi_cs_n is high after a stream
//   instr_data_in         last halfword fetched
//   instr_ready           pulse: instr_data_in newly valid
//   spi_*                 quad-SPI flash interface
module tinyqv_instr_fetch_qspi #(
    parameter int          DUMMY_CYCLES   = 4,
    parameter int          CS_HIGH_CYCLES = 2,
    parameter logic [7:0]  MODE_BYTE      = 8'hA0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [22:0] instr_addr,
    input  logic        instr_fetch_restart,
    input  logic        instr_fetch_stall,
    output logic        instr_fetch_started,
    output logic        instr_fetch_stopped,
    output logic [15:0] instr_data_in,
    output logic        instr_ready,
    output logic        spi_cs_n,
    output logic        spi_clk_out,
    output logic [3:0]  spi_data_out,
    output logic [3:0]  spi_data_oe,
    input  logic [3:0]  spi_data_in
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_MODE, S_DUMMY, S_DATA, S_STALLED, S_STOP
    } state_t;

    state_t      state_q, state_d;
    logic        phase_q, phase_d;      // 0: SPI clock low, 1: SPI clock high
    logic [4:0]  cnt_q, cnt_d;          // nibble index within the current state
    logic [23:0] addr_q, addr_d;
    logic        pending_q, pending_d;  // a restart is waiting for CS-high time
    logic [3:0]  cs_cnt_q, cs_cnt_d;    // cycles spent with cs high
    logic [11:0] shift_q, shift_d;
    logic        cs_n_q, cs_n_d;
    logic        sclk_q, sclk_d;
    logic [3:0]  dout_q, dout_d;
    logic [3:0]  oe_q, oe_d;
    logic        ready_q, ready_d;
    logic [15:0] data_q, data_d;
    logic        started_q, started_d;
    logic        stopped_q, stopped_d;

    logic [15:0] nib_new;
    logic        cs_done;
    logic        spi_active;

    assign nib_new = {shift_q, spi_data_in};
    assign cs_done = (cs_cnt_q >= 4'(CS_HIGH_CYCLES));

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        pending_d = pending_q;
        cs_cnt_d  = cs_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        ready_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cs_cnt_q != 4'hF) cs_cnt_d = cs_cnt_q + 4'd1;
                if (instr_fetch_restart) begin
                    addr_d    = {instr_addr, 1'b0};
                    pending_d = 1'b1;
                end
                if ((instr_fetch_restart || pending_q) && cs_done) begin
                    state_d   = S_ADDR;
                    pending_d = 1'b0;
                    phase_d   = 1'b0;
                    cnt_d     = 5'd0;
                end
            end
            S_STOP: begin
                // A restart here only replaces the pending address; the
                // CS-high time always runs to completion.
                if (instr_fetch_restart) begin
                    addr_d    = {instr_addr, 1'b0};
                    pending_d = 1'b1;
                end
                if (cs_done) begin
                    if (instr_fetch_restart || pending_q) begin
                        state_d   = S_ADDR;
                        pending_d = 1'b0;
                        phase_d   = 1'b0;
                        cnt_d     = 5'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cs_cnt_d = cs_cnt_q + 4'd1;
                end
            end
            default: begin
                if (instr_fetch_restart) begin
                    // cs is low: abandon the stream, any partial halfword is lost
                    addr_d    = {instr_addr, 1'b0};
                    pending_d = 1'b1;
                    state_d   = S_STOP;
                    cs_cnt_d  = 4'd1;
                end else begin
                    case (state_q)
                        S_ADDR: begin
                            phase_d = ~phase_q;
                            if (phase_q) begin
                                if (cnt_q == 5'd5) begin
                                    state_d = S_MODE;
                                    cnt_d   = 5'd0;
                                end else cnt_d = cnt_q + 5'd1;
                            end
                        end
                        S_MODE: begin
                            phase_d = ~phase_q;
                            if (phase_q) begin
                                if (cnt_q == 5'd1) begin
                                    state_d = S_DUMMY;
                                    cnt_d   = 5'd0;
                                end else cnt_d = cnt_q + 5'd1;
                            end
                        end
                        S_DUMMY: begin
                            phase_d = ~phase_q;
                            if (phase_q) begin
                                if (cnt_q == 5'(DUMMY_CYCLES - 1)) begin
                                    state_d = S_DATA;
                                    cnt_d   = 5'd0;
                                end else cnt_d = cnt_q + 5'd1;
                            end
                        end
                        S_DATA: begin
                            if (!phase_q) begin
                                // ready_q marks the halfword boundary; pausing
                                // here keeps the flash stream contiguous.
                                if (ready_q && instr_fetch_stall) state_d = S_STALLED;
                                else phase_d = 1'b1;
                            end else begin
                                phase_d = 1'b0;
                                shift_d = nib_new[11:0];
                                if (cnt_q == 5'd3) begin
                                    cnt_d   = 5'd0;
                                    ready_d = 1'b1;
                                    data_d  = {nib_new[7:0], nib_new[15:8]};
                                end else cnt_d = cnt_q + 5'd1;
                            end
                        end
                        S_STALLED: begin
                            if (!instr_fetch_stall) begin
                                state_d = S_DATA;
                                phase_d = 1'b0;
                            end
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
        endcase
    end

    // Outputs are registered decodes of the next state, so each output lines
    // up with the state it belongs to.
    always_comb begin
        spi_active = (state_d == S_ADDR) || (state_d == S_MODE) ||
                     (state_d == S_DUMMY) || (state_d == S_DATA);
        cs_n_d     = (state_d == S_IDLE) || (state_d == S_STOP);
        sclk_d     = spi_active && phase_d;
        oe_d       = ((state_d == S_ADDR) || (state_d == S_MODE)) ? 4'hF : 4'h0;
        dout_d     = 4'h0;
        if (state_d == S_ADDR) begin
            case (cnt_d[2:0])
                3'd0:    dout_d = addr_d[23:20];
                3'd1:    dout_d = addr_d[19:16];
                3'd2:    dout_d = addr_d[15:12];
                3'd3:    dout_d = addr_d[11:8];
                3'd4:    dout_d = addr_d[7:4];
                default: dout_d = addr_d[3:0];
            endcase
        end else if (state_d == S_MODE) begin
            dout_d = cnt_d[0] ? MODE_BYTE[3:0] : MODE_BYTE[7:4];
        end
        started_d = (state_d == S_ADDR) && (state_q != S_ADDR);
        stopped_d = (state_d == S_STOP) && (state_q != S_STOP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            phase_q   <= 1'b0;
            cnt_q     <= 5'd0;
            addr_q    <= 24'd0;
            pending_q <= 1'b0;
            cs_cnt_q  <= 4'(CS_HIGH_CYCLES);
            shift_q   <= 12'd0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b0;
            dout_q    <= 4'h0;
            oe_q      <= 4'h0;
            ready_q   <= 1'b0;
            data_q    <= 16'd0;
            started_q <= 1'b0;
            stopped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            pending_q <= pending_d;
            cs_cnt_q  <= cs_cnt_d;
            shift_q   <= shift_d;
            cs_n_q    <= cs_n_d;
            sclk_q    <= sclk_d;
            dout_q    <= dout_d;
            oe_q      <= oe_d;
            ready_q   <= ready_d;
            data_q    <= data_d;
            started_q <= started_d;
            stopped_q <= stopped_d;
        end
    end

    assign spi_cs_n            = cs_n_q;
    assign spi_clk_out         = sclk_q;
    assign spi_data_out        = dout_q;
    assign spi_data_oe         = oe_q;
    assign instr_ready         = ready_q;
    assign instr_data_in       = data_q;
    assign instr_fetch_started = started_q;
    assign instr_fetch_stopped = stopped_q;

endmodule

// File: doc/tinyqv_instr_fetch_qspi.md
Name: tinyqv_instr_fetch_qspi

Overview:
- Instruction-fetch front end directly upstream of tinyqv_cpu.
- Turns the CPU fetch requests (instr_addr, instr_fetch_restart, instr_fetch_stall) into quad-SPI continuous-read transactions on an external flash.
- Returns instructions as 16-bit halfwords on instr_data_in / instr_ready, and reports transaction start and end via instr_fetch_started / instr_fetch_stopped.
- Flash is pre-configured for continuous quad read (0xEB mode): no command byte is sent.

Parameters:
- DUMMY_CYCLES, 4, SPI clock cycles between the mode byte and the first data nibble.
- CS_HIGH_CYCLES, 2, minimum clk cycles spi_cs_n is held high between transactions (range 1..15).
- MODE_BYTE, 8'hA0, continuous-read mode byte sent after the address.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- instr_addr  input  23  halfword address [23:1]; byte address is {instr_addr, 1'b0}; sampled when instr_fetch_restart=1
- instr_fetch_restart  input  1  one-cycle pulse: abandon any current stream and start fetching at instr_addr
- instr_fetch_stall  input  1  level: pause the stream at the next halfword boundary
- instr_fetch_started  output  1  one-cycle pulse when the address phase begins
- instr_fetch_stopped  output  1  one-cycle pulse when spi_cs_n rises after a stream ends
- instr_data_in  output  16  last halfword fetched; held until the next instr_ready
- instr_ready  output  1  one-cycle pulse: instr_data_in is newly valid
- spi_cs_n  output  1  flash chip select, active low
- spi_clk_out  output  1  flash SPI clock
- spi_data_out  output  4  quad data to flash
- spi_data_oe  output  4  output enables, 1 = drive
- spi_data_in  input  4  quad data from flash

Behaviour:
- Reset (asynchronous; outputs take these values immediately):
  - spi_cs_n=1, spi_clk_out=0, spi_data_oe=0, spi_data_out=0
  - instr_ready=0, instr_data_in=0, instr_fetch_started=0, instr_fetch_stopped=0
  - State = IDLE; CS-high counter preloaded to CS_HIGH_CYCLES, so the first restart after reset is not delayed.
- Nibble timing: each SPI nibble takes 2 clk cycles.
  - Phase 0: spi_clk_out=0; the new nibble is driven on spi_data_out.
  - Phase 1: spi_clk_out=1; spi_data_in is registered at the end of phase 1.
  - spi_clk_out is 0 in every state except ADDR, MODE, DUMMY and DATA.
- States:
  - IDLE: cs high. A restart latches the byte address into a 24-bit register and enters ADDR on the next cycle.
  - ADDR: cs low, oe=4'hF. Sends 6 nibbles of the byte address, MSB first. instr_fetch_started pulses in the first ADDR cycle.
  - MODE: oe=4'hF. Sends 2 nibbles of MODE_BYTE, high nibble first.
  - DUMMY: oe=0. Runs DUMMY_CYCLES SPI clocks (2*DUMMY_CYCLES clk cycles).
  - DATA: oe=0. Shifts in 4 nibbles per halfword, in the order b0[7:4], b0[3:0], b1[7:4], b1[3:0]. Halfword = {b1, b0} (little-endian).
    - instr_data_in is updated and instr_ready pulses in the cycle after the 4th nibble is sampled.
    - Data cadence: one halfword every 8 clk cycles after the first.
  - STALLED: cs stays low, spi_clk_out=0, oe=0.
  - STOP: cs high for CS_HIGH_CYCLES cycles, then IDLE. instr_fetch_stopped pulses in the first STOP cycle.
- Stall:
  - Stall is evaluated at each halfword boundary (the cycle instr_ready pulses). If instr_fetch_stall=1, the next state is STALLED and no further SPI clock edges occur.
  - Leaving STALLED: when instr_fetch_stall=0, DATA resumes at phase 0 of the next nibble. The flash stream is contiguous, so no halfword is lost or duplicated.
  - Stall asserted mid-halfword takes effect only at the boundary.
- Restart while cs is low (any of ADDR, MODE, DUMMY, DATA, STALLED):
  - Latch the new address and go to STOP immediately.
  - Any partial halfword is discarded; no instr_ready is issued for it.
  - After STOP, go straight to ADDR, skipping IDLE.
- Restart during STOP: latch the new address, replacing any pending one. Complete the CS-high time, then go to ADDR.
- Restart in IDLE when fewer than CS_HIGH_CYCLES cycles have passed since cs rose: wait out the remainder first.
- Restart and stall in the same cycle: restart wins.
- A restart in the same cycle as an instr_ready pulse still produces that pulse.
- Address wraps modulo 2^24 inside the flash; the block does not count the data address.

Test Plan:
- Restart with instr_addr=23'h000010 (byte 0x000020), defaults:
  - spi_data_out carries nibbles 0,0,0,0,2,0, then A,0 with oe=F.
  - instr_fetch_started pulses in the first ADDR cycle; 4 dummy SPI clocks follow with oe=0.
  - Flash returns bytes 0x13, 0x05 → instr_data_in=16'h0513 with instr_ready; the first pulse arrives 32 clk cycles after the ADDR phase begins.
- Continuous stream of bytes 0x11..0x18 → four instr_ready pulses 8 cycles apart, with data 16'h1211, 16'h1413, 16'h1615, 16'h1817.
- instr_fetch_stall raised 3 cycles before the 2nd halfword and held 20 cycles:
  - 2nd instr_ready still pulses; no SPI edges while stalled; cs stays low.
  - After release, the 3rd halfword equals flash bytes 4..5.
- Restart during DATA, mid-halfword, with a new address:
  - No instr_ready for the partial halfword; instr_fetch_stopped pulses; cs high for exactly 2 cycles.
  - New address then appears on spi_data_out.
- Reset asserted during DUMMY → immediately cs=1, oe=0, spi_clk_out=0, instr_ready=0. After release, the block is idle until the next restart.
- Restart and stall in the same cycle while in DATA → the STOP sequence runs (restart wins) and the new fetch begins.
